// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   INSTR_W          instruction word width
//   NOP_INSTR        word shown to decode when no instruction is buffered
//   RESET_PC_DEFAULT default reset PC
//   fetch_state_e    fetch control states (S_REQ / S_WAIT / S_DISCARD)
package instr_fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,  // request issuable (or being issued this cycle)
    S_WAIT    = 2'd1,  // request outstanding, response will be kept
    S_DISCARD = 2'd2   // request outstanding, response will be dropped
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i/wdata_i  write an entry (accepted when not full, or full with pop)
//   pop_i           remove head (ignored when empty)
//   flush_i         empty the FIFO; overrides push and pop in the same cycle
//   head_o          head entry (only meaningful when count_o != 0)
//   count_o         number of valid entries
module instr_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~flush_i & ~empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i & ~flush_i & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches to a
// variable-latency instruction memory, buffers {pc, instr} in a FIFO and
// hands them to decode over valid/ready. Accepts redirects from downstream.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   imem_req/imem_addr     fetch request, held with stable address until ack
//   imem_ack/imem_rdata    response strobe and returned word
//   redirect/redirect_pc   one-cycle flush-and-restart pulse and target
//   instru/instr_pc        FIFO head word and its PC (NOP / RESET_PC when empty)
//   instr_valid/ready      decode handshake
//   dbg_state              current fetch control state
//   perf_fetched/dropped   event counters, present only with IFETCH_PERF_EN
// Handshakes: an imem transfer completes in any cycle with imem_req & imem_ack;
// once raised, imem_req and imem_addr hold until that cycle (a redirect in
// S_REQ without ack is the one case that retracts an unanswered request).
// A decode transfer completes in any cycle with instr_valid & instr_ready;
// instru/instr_pc hold while instr_valid & ~instr_ready.
// Optional feature macro: IFETCH_PERF_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [INSTR_W-1:0] instru,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output fetch_state_e       dbg_state
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        addr_q, addr_d;
  logic               run_q;
  logic               push, pop;
  logic [CW-1:0]      count;
  logic [31:0]        head_pc;
  logic [INSTR_W-1:0] head_instr;

  // run_q keeps imem_req low in the first cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    push      = 1'b0;
    imem_req  = 1'b0;
    imem_addr = addr_q;
    case (state_q)
      S_REQ: begin
        // An issued-but-unanswered request reserves a slot, so issuing only
        // when a slot is free guarantees the response always fits.
        imem_addr = pc_q;
        imem_req  = run_q & (count != FULL_CNT);
        if (imem_req) begin
          addr_d = pc_q;
          if (imem_ack) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect) begin
      pc_d = redirect_pc & ~32'h3;
      push = 1'b0;
      // A request still unanswered at the memory must run to completion;
      // its response is then thrown away in S_DISCARD.
      if (state_q == S_REQ || imem_ack) state_d = S_REQ;
      else                              state_d = S_DISCARD;
    end
  end

  assign pop = instr_valid & instr_ready;

  instr_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32 + INSTR_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i ({pc_q, imem_rdata}),
    .head_o  ({head_pc, head_instr}),
    .count_o (count)
  );

  assign instr_valid = (count != '0);
  assign instru      = instr_valid ? head_instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head_pc    : RESET_PC;
  assign dbg_state   = state_q;

`ifdef IFETCH_PERF_EN
  logic [31:0]   fetched_q, dropped_q;
  logic          drop_resp;
  logic [CW-1:0] flushed;

  // Dropped = responses thrown away plus buffered entries lost to a flush
  // (an entry popped in the flush cycle reached decode and is not lost).
  assign drop_resp = imem_ack & imem_req & ((state_q == S_DISCARD) | redirect);
  assign flushed   = redirect ? (count - CW'(pop)) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(push);
      dropped_q <= dropped_q + 32'(drop_resp) + 32'(flushed);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (RESET_PC = 0, FIFO_DEPTH = 2).
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [INSTR_W-1:0] instru;
  logic [31:0]        instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  fetch_state_e       dbg_state;
`ifdef IFETCH_PERF_EN
  logic [31:0]        perf_fetched, perf_dropped;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instru      (instru),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .dbg_state   (dbg_state)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata,
                       input logic ready, input logic redir, input logic [31:0] rpc);
    imem_ack    = ack;
    imem_rdata  = rdata;
    instr_ready = ready;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instru,           32'h0);
    chk("rst_pc",    instr_pc,         32'h0);
    chk("rst_state", 32'(dbg_state),   32'(S_REQ));
    next();
    next();

    // Release: no request in the first cycle after release.
    reset = 1'b1;
    #1;
    chk("first_cycle_req", 32'(imem_req), 32'd0);
    next();

    // Zero-wait memory, decode always ready: one instruction per cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 32'h0);
      #1;
      chk("zw_req",  32'(imem_req), 32'd1);
      chk("zw_addr", imem_addr,     32'(4 * i));
      if (i > 0) begin
        chk("zw_valid", 32'(instr_valid), 32'd1);
        chk("zw_pc",    instr_pc,         32'(4 * (i - 1)));
        chk("zw_instr", instru,           32'hA000_0000 + 32'(i - 1));
      end
      next();
    end

    // Decode stalls: buffer fills to two entries then requests stop.
    drive(1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'h0);
    #1;
    chk("st_req",  32'(imem_req), 32'd1);
    chk("st_addr", imem_addr,     32'd24);
    chk("st_pc",   instr_pc,      32'd20);
    next();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_req",   32'(imem_req),    32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_pc",    instr_pc,         32'd20);
      chk("stall_instr", instru,           32'hA000_0005);
      next();
    end

    // Drain: exactly the two buffered words, then fetch resumes at 28.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("drain0_pc",  instr_pc,      32'd20);
    chk("drain0_req", 32'(imem_req), 32'd0);
    next();
    #1;
    chk("drain1_pc",    instr_pc,      32'd24);
    chk("drain1_instr", instru,        32'hB000_0000);
    chk("drain1_req",   32'(imem_req), 32'd1);
    chk("drain1_addr",  imem_addr,     32'd28);
    next();

    // Slow memory: ack three cycles after the request.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wait_state", 32'(dbg_state),   32'(S_WAIT));
      chk("wait_req",   32'(imem_req),    32'd1);
      chk("wait_addr",  imem_addr,        32'd28);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      next();
    end
    drive(1'b1, 32'hC000_0000, 1'b0, 1'b0, 32'h0);
    #1;
    chk("ack_addr",  imem_addr,        32'd28);
    chk("ack_valid", 32'(instr_valid), 32'd0);
    next();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("slow_valid", 32'(instr_valid), 32'd1);
    chk("slow_pc",    instr_pc,         32'd28);
    chk("slow_instr", instru,           32'hC000_0000);
    chk("slow_addr",  imem_addr,        32'd32);
    next();

    // Redirect while waiting: outstanding response is discarded.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    #1;
    chk("rd_state", 32'(dbg_state), 32'(S_WAIT));
    next();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("disc_state", 32'(dbg_state),   32'(S_DISCARD));
    chk("disc_req",   32'(imem_req),    32'd1);
    chk("disc_addr",  imem_addr,        32'd32);
    chk("disc_valid", 32'(instr_valid), 32'd0);
    next();
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    #1;
    chk("disc_ack_addr", imem_addr, 32'd32);
    next();
    drive(1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0);
    #1;
    chk("nostale_valid", 32'(instr_valid), 32'd0);
    chk("refetch_addr",  imem_addr,        32'h0000_0100);
    chk("refetch_req",   32'(imem_req),    32'd1);
    next();
    drive(1'b1, 32'h1111_0004, 1'b0, 1'b0, 32'h0);
    #1;
    chk("refetch_pc",    instr_pc,  32'h0000_0100);
    chk("refetch_instr", instru,    32'h1111_0000);
    chk("refetch_addr2", imem_addr, 32'h0000_0104);
    next();

    // Full FIFO, pop and redirect together: FIFO empties, fetch at target.
    drive(1'b1, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0200);
    #1;
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_pc",  instr_pc,      32'h0000_0100);
    next();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_addr",  imem_addr,        32'h0000_0200);
    chk("flush_req",   32'(imem_req),    32'd1);
    next();
    drive(1'b1, 32'h2222_0000, 1'b0, 1'b0, 32'h0);
    #1;
    chk("w2_state", 32'(dbg_state), 32'(S_WAIT));
    next();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("w2_pc",   instr_pc,  32'h0000_0200);
    chk("w2_addr", imem_addr, 32'h0000_0204);
    next();

    // One entry buffered plus one outstanding: ack + pop + redirect together.
    drive(1'b1, 32'h3333_0000, 1'b1, 1'b1, 32'h0000_0301);
    #1;
    chk("ackredir_state", 32'(dbg_state), 32'(S_WAIT));
    next();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("ackredir_valid", 32'(instr_valid), 32'd0);
    chk("ackredir_state2", 32'(dbg_state),  32'(S_REQ));
    chk("ackredir_addr",  imem_addr,        32'h0000_0300);
    next();

    // Reset asserted mid-wait: outputs return to reset values at once.
    #1;
    chk("pre_rst_state", 32'(dbg_state), 32'(S_WAIT));
    reset = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req),    32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", instru,           32'h0);
    chk("arst_pc",    instr_pc,         32'h0);
    chk("arst_state", 32'(dbg_state),   32'(S_REQ));
    next();
    reset = 1'b1;
    #1;
    chk("rel_req", 32'(imem_req), 32'd0);
    next();
    drive(1'b1, 32'h4444_0000, 1'b1, 1'b0, 32'h0);
    #1;
    chk("restart_req",  32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr,     32'h0);
    next();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("restart_valid", 32'(instr_valid), 32'd1);
    chk("restart_pc",    instr_pc,         32'h0);
    chk("restart_instr", instru,           32'h4444_0000);
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
